// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin arbiter sharing one data memory between the CPU
//            load/store path and the program/data loader. Each accepted
//            access is latched, driven to memory for one cycle and answered
//            with a one-cycle response pulse.
// Revision : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int DEPTH  = 128,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  // CPU port
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  // Loader port
  input  logic              dma_req_i,
  input  logic              dma_we_i,
  input  logic [31:0]       dma_addr_i,
  input  logic [DATA_W-1:0] dma_wdata_i,
  output logic              dma_gnt_o,
  output logic              dma_rvalid_o,
  output logic [DATA_W-1:0] dma_rdata_o,
  // Shared response flag
  output logic              rsp_err_o,
  // Memory side
  output logic [31:0]       mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o
);

  localparam logic [29:0] c_DEPTH = 30'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  // Owner encoding: 0 = CPU, 1 = loader
  state_e              state_q, state_d;
  logic                owner_q;
  logic                last_owner_q;
  logic                we_q;
  logic [29:0]         word_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                err_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                w_cpu_win;
  logic                w_dma_win;
  logic                w_grant;
  logic                w_in_range;
  logic                w_resp;

  // On a tie the requester that did not win last time takes the slot.
  assign w_cpu_win  = cpu_req_i & (~dma_req_i | last_owner_q);
  assign w_dma_win  = dma_req_i & ~w_cpu_win;
  assign w_in_range = (word_q < c_DEPTH);
  assign w_resp     = (state_q == S_RESP);

  // Next-state, grant and memory strobe decode; grants are blocked while in reset.
  always_comb begin
    state_d     = state_q;
    cpu_gnt_o   = 1'b0;
    dma_gnt_o   = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    w_grant     = 1'b0;
    case (state_q)
      S_IDLE, S_RESP: begin
        cpu_gnt_o = rst_ni & w_cpu_win;
        dma_gnt_o = rst_ni & w_dma_win;
        w_grant   = rst_ni & (w_cpu_win | w_dma_win);
        state_d   = w_grant ? S_ACCESS : S_IDLE;
      end
      S_ACCESS: begin
        mem_read_o  = w_in_range & ~we_q;
        mem_write_o = w_in_range & we_q;
        state_d     = S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; async reset aborts any in-flight access immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Latch the winner's request on grant and capture the access result in ACCESS.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      we_q         <= 1'b0;
      word_q       <= '0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      if (w_grant) begin
        owner_q      <= w_dma_win;
        last_owner_q <= w_dma_win;
        we_q         <= w_dma_win ? dma_we_i         : cpu_we_i;
        word_q       <= w_dma_win ? dma_addr_i[31:2] : cpu_addr_i[31:2];
        wdata_q      <= w_dma_win ? dma_wdata_i      : cpu_wdata_i;
      end
      if (state_q == S_ACCESS) begin
        err_q   <= ~w_in_range;
        rdata_q <= (~we_q & w_in_range) ? mem_rdata_i : '0;
      end
    end
  end

  assign cpu_rvalid_o = w_resp & ~owner_q;
  assign dma_rvalid_o = w_resp & owner_q;
  assign cpu_rdata_o  = cpu_rvalid_o ? rdata_q : '0;
  assign dma_rdata_o  = dma_rvalid_o ? rdata_q : '0;
  assign rsp_err_o    = w_resp & err_q;
  assign mem_addr_o   = {word_q, 2'b00};
  assign mem_wdata_o  = wdata_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule
`default_nettype wire
